// File: rtl/lut_neuron_rt_pkg.sv
// Shared types and helpers for the lut_neuron_rt layer.
package lut_neuron_rt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Width of a neuron index; a single-neuron layer still gets a 1-bit select.
    function automatic int nidx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_neuron_rt_if.sv
// Valid/ready streaming bundle for the lut_neuron_rt layer (input beat in, activations out).
interface lut_neuron_rt_if #(
    parameter int IN_BITS     = 8,
    parameter int OUT_BITS    = 2,
    parameter int NUM_NEURONS = 4
);
    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_NEURONS*IN_BITS-1:0]  in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_NEURONS*OUT_BITS-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/lut_neuron_rt_table.sv
// One neuron truth table: write port, registered lookup port, optional async readback port
// (readback present when LUT_NEURON_RT_READBACK_EN is defined).
module lut_neuron_rt_table
    import lut_neuron_rt_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [IN_BITS-1:0]  waddr,
    input  logic [OUT_BITS-1:0] wdata,
    input  logic                rd_en,
    input  logic [IN_BITS-1:0]  raddr,
    output logic [OUT_BITS-1:0] rd_data
`ifdef LUT_NEURON_RT_READBACK_EN
    ,
    input  logic [IN_BITS-1:0]  rb_addr,
    output logic [OUT_BITS-1:0] rb_data
`endif
);
    localparam int DEPTH = 2 ** IN_BITS;

    logic [OUT_BITS-1:0] mem_r [DEPTH];
    logic [OUT_BITS-1:0] rd_data_r;

    // Table storage: never reset so contents survive a layer reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered lookup, frozen while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {OUT_BITS{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[raddr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

`ifdef LUT_NEURON_RT_READBACK_EN
    assign rb_data = mem_r[rb_addr];
`endif

endmodule

// File: rtl/lut_neuron_rt.sv
// Runtime-loadable two-stage LUT neuron layer with valid/ready streaming and a load/run FSM.
// Define LUT_NEURON_RT_READBACK_EN to add the cfg_re/cfg_rdata table readback port.
module lut_neuron_rt
    import lut_neuron_rt_pkg::*;
#(
    parameter int IN_BITS     = 8,
    parameter int OUT_BITS    = 2,
    parameter int NUM_NEURONS = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_start,
    input  logic                                  cfg_we,
    input  logic [nidx_width(NUM_NEURONS)-1:0]    cfg_neuron,
    input  logic [IN_BITS-1:0]                    cfg_addr,
    input  logic [OUT_BITS-1:0]                   cfg_wdata,
    input  logic                                  cfg_commit,
    output logic                                  cfg_err,
    output logic                                  run,
`ifdef LUT_NEURON_RT_READBACK_EN
    input  logic                                  cfg_re,
    output logic [OUT_BITS-1:0]                   cfg_rdata,
`endif
    lut_neuron_rt_if.slave                        s
);
    localparam int NW = nidx_width(NUM_NEURONS);

    state_e                          state_r;
    state_e                          state_nx_s;
    logic                            en_s;
    logic                            in_ready_s;
    logic                            idx_ok_s;
    logic                            we_ok_s;
    logic                            err_s;
    logic                            re_s;
    logic                            v1_r;
    logic                            out_valid_r;
    logic                            cfg_err_r;
    logic                            run_r;
    logic [NUM_NEURONS*OUT_BITS-1:0] rd_data_s;
    logic [NUM_NEURONS*OUT_BITS-1:0] out_data_r;

    // Non-power-of-two layers leave select codes with no table behind them.
    assign idx_ok_s = (int'(cfg_neuron) < NUM_NEURONS);

`ifdef LUT_NEURON_RT_READBACK_EN
    logic [OUT_BITS-1:0] rb_data_s [NUM_NEURONS];
    logic [OUT_BITS-1:0] rb_sel_s;
    logic [OUT_BITS-1:0] cfg_rdata_r;
    logic                re_ok_s;

    assign re_s    = cfg_re;
    assign re_ok_s = cfg_re && (state_r == ST_LOAD) && idx_ok_s;

    // Readback select: AND-OR mux across the tables.
    always_comb begin
        rb_sel_s = {OUT_BITS{1'b0}};
        for (int k = 0; k < NUM_NEURONS; k++) begin
            rb_sel_s = rb_sel_s | (rb_data_s[k] & {OUT_BITS{cfg_neuron == NW'(k)}});
        end
    end

    // Readback result register, held until the next accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rdata_r <= {OUT_BITS{1'b0}};
        end else if (re_ok_s) begin
            cfg_rdata_r <= rb_sel_s;
        end else begin
            cfg_rdata_r <= cfg_rdata_r;
        end
    end

    assign cfg_rdata = cfg_rdata_r;
`else
    assign re_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; DRAIN waits for both pipeline stages to empty.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:  state_nx_s = cfg_start  ? ST_LOAD  : ST_IDLE;
            ST_LOAD:  state_nx_s = cfg_commit ? ST_RUN   : ST_LOAD;
            ST_RUN:   state_nx_s = cfg_start  ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nx_s = (!v1_r && !out_valid_r) ? ST_LOAD : ST_DRAIN;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs: stream acceptance, table write qualification, config error detect.
    always_comb begin
        en_s       = !out_valid_r || s.out_ready;
        in_ready_s = 1'b0;
        we_ok_s    = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                err_s = cfg_we || cfg_commit || re_s;
            end
            ST_LOAD: begin
                we_ok_s = cfg_we && idx_ok_s;
                err_s   = (cfg_we || re_s) && !idx_ok_s;
            end
            ST_RUN: begin
                in_ready_s = en_s;
                err_s      = cfg_we || re_s;
            end
            ST_DRAIN: begin
                err_s = cfg_we || re_s;
            end
            default: begin
                in_ready_s = 1'b0;
                we_ok_s    = 1'b0;
                err_s      = 1'b0;
            end
        endcase
    end

    for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_tbl
        localparam logic [NW-1:0] IDX = NW'(k);

        lut_neuron_rt_table #(
            .IN_BITS  (IN_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_tbl (
            .clk     (clk),
            .rst     (rst),
            .we      (we_ok_s && (cfg_neuron == IDX)),
            .waddr   (cfg_addr),
            .wdata   (cfg_wdata),
            .rd_en   (en_s),
            .raddr   (s.in_data[k*IN_BITS +: IN_BITS]),
            .rd_data (rd_data_s[k*OUT_BITS +: OUT_BITS])
`ifdef LUT_NEURON_RT_READBACK_EN
            ,
            .rb_addr (cfg_addr),
            .rb_data (rb_data_s[k])
`endif
        );
    end

    // Pipeline valids and output register; everything advances together on en.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r        <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {(NUM_NEURONS*OUT_BITS){1'b0}};
        end else if (en_s) begin
            v1_r        <= s.in_valid && in_ready_s;
            out_valid_r <= v1_r;
            out_data_r  <= rd_data_s;
        end else begin
            v1_r        <= v1_r;
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
        end
    end

    // Status flags: error pulse follows the offending strobe, run tracks the RUN state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err_r <= 1'b0;
            run_r     <= 1'b0;
        end else begin
            cfg_err_r <= err_s;
            run_r     <= (state_nx_s == ST_RUN);
        end
    end

    assign s.in_ready  = in_ready_s;
    assign s.out_valid = out_valid_r;
    assign s.out_data  = out_data_r;
    assign cfg_err     = cfg_err_r;
    assign run         = run_r;

endmodule

// File: tb/tb_lut_neuron_rt.sv
// Self-checking bench for lut_neuron_rt: table model + expected-beat queue, config vector table.
module tb_lut_neuron_rt;
    import lut_neuron_rt_pkg::*;

    // Three neurons on a 2-bit select so an out-of-range neuron index can be driven.
    localparam int IB = 8;
    localparam int OB = 2;
    localparam int NN = 3;
    localparam int NW = nidx_width(NN);

    logic          clk;
    logic          rst;
    logic          cfg_start;
    logic          cfg_we;
    logic [NW-1:0] cfg_neuron;
    logic [IB-1:0] cfg_addr;
    logic [OB-1:0] cfg_wdata;
    logic          cfg_commit;
    logic          cfg_err;
    logic          run;
`ifdef LUT_NEURON_RT_READBACK_EN
    logic          cfg_re;
    logic [OB-1:0] cfg_rdata;
`endif

    lut_neuron_rt_if #(.IN_BITS(IB), .OUT_BITS(OB), .NUM_NEURONS(NN)) bus ();

    lut_neuron_rt #(.IN_BITS(IB), .OUT_BITS(OB), .NUM_NEURONS(NN)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_we     (cfg_we),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_commit (cfg_commit),
        .cfg_err    (cfg_err),
        .run        (run),
`ifdef LUT_NEURON_RT_READBACK_EN
        .cfg_re     (cfg_re),
        .cfg_rdata  (cfg_rdata),
`endif
        .s          (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: the tables as plain arrays, plus a queue of expected beats.
    logic [OB-1:0] model [NN][256];

    typedef struct {
        logic [NN*OB-1:0] data;
        int               cyc;
    } beat_t;

    beat_t q[$];
    int    cyc     = 0;
    int    n_acc   = 0;
    bit    chk_lat = 1'b0;
    bit    stall_prev = 1'b0;
    logic [NN*OB-1:0] held;

    function automatic logic [NN*OB-1:0] ref_out(input logic [NN*IB-1:0] d);
        logic [NN*OB-1:0] r = {(NN*OB){1'b0}};
        for (int k = 0; k < NN; k++) r[k*OB +: OB] = model[k][d[k*IB +: IB]];
        return r;
    endfunction

    function automatic logic [NN*IB-1:0] rand_data();
        logic [NN*IB-1:0] d;
        for (int k = 0; k < NN; k++) d[k*IB +: IB] = IB'($urandom);
        return d;
    endfunction

    // Monitor on the falling edge: handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 64'(bus.out_valid), 64'd1);
                chk("stall_data", 64'(bus.out_data), 64'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_beat", 64'd1, 64'd0);
                end else begin
                    b = q.pop_front();
                    chk("out_data", 64'(bus.out_data), 64'(b.data));
                    if (chk_lat) chk("latency", 64'(cyc - b.cyc), 64'd2);
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held       = bus.out_data;
            if (bus.in_valid && bus.in_ready) begin
                b.data = ref_out(bus.in_data);
                b.cyc  = cyc;
                q.push_back(b);
                n_acc++;
            end
        end
        cyc++;
    end

    task automatic cfg_cycle(input bit st, input bit we, input logic [NW-1:0] n,
                             input logic [IB-1:0] a, input logic [OB-1:0] d, input bit cm);
        cfg_start  = st;
        cfg_we     = we;
        cfg_neuron = n;
        cfg_addr   = a;
        cfg_wdata  = d;
        cfg_commit = cm;
        @(posedge clk); #1;
        cfg_start  = 1'b0;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic stream(input int ncyc, input bit rnd);
        for (int i = 0; i < ncyc; i++) begin
            bus.in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_data   = rand_data();
            bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (q.size() != 0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk(nm, 64'(q.size()), 64'd0);
    endtask

    task automatic put_beat(input logic [NN*IB-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    typedef struct {
        bit            start;
        bit            we;
        bit            commit;
        logic [NW-1:0] n;
        logic [IB-1:0] a;
        logic [OB-1:0] d;
        bit            lands;
        bit            exp_err;
        bit            exp_run;
    } cfg_vec_t;

    cfg_vec_t vt [12];

    initial begin
        int errs;
        int a0;
        bit got;

        // Config vectors applied from IDLE after a mid-stream reset.
        vt[0]  = '{1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0}; // commit in IDLE
        vt[1]  = '{1'b0, 1'b1, 1'b0, 2'd2, 8'h03, 2'd2, 1'b0, 1'b1, 1'b0}; // write in IDLE
        vt[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0}; // start
        vt[3]  = '{1'b0, 1'b1, 1'b0, 2'd3, 8'h05, 2'd3, 1'b0, 1'b1, 1'b0}; // bad neuron
        vt[4]  = '{1'b0, 1'b1, 1'b0, 2'd1, 8'h77, 2'd1, 1'b1, 1'b0, 1'b0}; // good write
        vt[5]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0}; // start in LOAD
        vt[6]  = '{1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1}; // commit
        vt[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h01, 2'd2, 1'b0, 1'b1, 1'b1}; // write in RUN
        vt[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1}; // idle
        vt[9]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0}; // start -> DRAIN
        vt[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0}; // DRAIN -> LOAD
        vt[11] = '{1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1}; // commit

        rst = 1'b1;
        cfg_start = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
        cfg_neuron = {NW{1'b0}}; cfg_addr = 8'h00; cfg_wdata = 2'd0;
`ifdef LUT_NEURON_RT_READBACK_EN
        cfg_re = 1'b0;
`endif
        bus.in_valid = 1'b0; bus.in_data = {(NN*IB){1'b0}}; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        chk("rst_run", 64'(run), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;

        // Load every table with addr[1:0] ^ neuron.
        cfg_cycle(1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0);
        errs = 0;
        for (int n = 0; n < NN; n++) begin
            for (int a = 0; a < 256; a++) begin
                cfg_cycle(1'b0, 1'b1, NW'(n), IB'(a), OB'(a) ^ OB'(n), 1'b0);
                errs += int'(cfg_err);
                model[n][a] = OB'(a) ^ OB'(n);
            end
        end
        chk("load_err_count", 64'(errs), 64'd0);
        cfg_cycle(1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1);
        chk("commit_run", 64'(run), 64'd1);
        chk("commit_in_ready", 64'(bus.in_ready), 64'd1);

        // Full sweep at one beat per cycle, latency checked.
        a0 = n_acc;
        chk_lat = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.in_valid = 1'b1;
            for (int k = 0; k < NN; k++) bus.in_data[k*IB +: IB] = IB'(i);
            @(posedge clk); #1;
        end
        drain("sweep_drain");
        chk_lat = 1'b0;
        chk("sweep_beats", 64'(n_acc - a0), 64'd256);

        // Random traffic with random backpressure.
        stream(150, 1'b1);
        drain("rand_drain");

        // Five-cycle stall with the pipeline full.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        repeat (3) begin
            bus.in_data = rand_data();
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        for (int st = 0; st < 5; st++) begin
            bus.in_data = rand_data();
            @(posedge clk); #1;
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        drain("stall_drain");

        // cfg_start with two beats in flight, then rewrite neuron 0 entry 0.
        bus.in_valid = 1'b1;
        bus.in_data  = rand_data();
        @(posedge clk); #1;
        bus.in_data = rand_data();
        cfg_start   = 1'b1;
        @(posedge clk); #1;
        cfg_start    = 1'b0;
        bus.in_valid = 1'b0;
        chk("drain_run_low", 64'(run), 64'd0);
        drain("drain_inflight");
        repeat (3) @(posedge clk);
        #1;
        cfg_cycle(1'b0, 1'b1, 2'd0, 8'h00, 2'b11, 1'b0);
        model[0][0] = 2'b11;
        chk("rewrite_err", 64'(cfg_err), 64'd0);
        cfg_cycle(1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1);
        chk("rewrite_run", 64'(run), 64'd1);
        put_beat({(NN*IB){1'b0}});
        got = 1'b0;
        for (int t = 0; t < 5 && !got; t++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                got = 1'b1;
                chk("n0_rewritten", 64'(bus.out_data[OB-1:0]), 64'd3);
            end
        end
        chk("n0_seen", 64'(got), 64'd1);
        drain("rewrite_drain");

        // Reset in the middle of a stream.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        repeat (3) begin
            bus.in_data = rand_data();
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_run", 64'(run), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;

        // Config vector table from IDLE; dropped writes must leave the model untouched.
        for (int i = 0; i < 12; i++) begin
            cfg_cycle(vt[i].start, vt[i].we, vt[i].n, vt[i].a, vt[i].d, vt[i].commit);
            if (vt[i].lands) model[int'(vt[i].n)][vt[i].a] = vt[i].d;
            chk($sformatf("vec%0d_err", i), 64'(cfg_err), 64'(vt[i].exp_err));
            chk($sformatf("vec%0d_run", i), 64'(run), 64'(vt[i].exp_run));
        end
        chk("vec_err_pulse", 64'(cfg_err), 64'd0);

        // Retained tables: hit the touched entries, then random traffic.
        put_beat({8'h03, 8'h77, 8'h01});
        put_beat({8'h05, 8'h05, 8'h00});
        put_beat(rand_data());
        drain("retain_drain");
        stream(100, 1'b1);
        drain("retain_rand_drain");

`ifdef LUT_NEURON_RT_READBACK_EN
        cfg_cycle(1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        cfg_cycle(1'b0, 1'b1, 2'd1, 8'h5A, 2'b10, 1'b0);
        model[1][8'h5A] = 2'b10;
        cfg_re = 1'b1; cfg_neuron = 2'd1; cfg_addr = 8'h5A;
        @(posedge clk); #1;
        cfg_re = 1'b0;
        chk("readback", 64'(cfg_rdata), 64'd2);
        cfg_addr = 8'h00;
        @(posedge clk); #1;
        chk("readback_hold", 64'(cfg_rdata), 64'd2);
        cfg_cycle(1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1);
        cfg_re = 1'b1;
        @(posedge clk); #1;
        cfg_re = 1'b0;
        chk("readback_run_err", 64'(cfg_err), 64'd1);
        put_beat({8'h00, 8'h5A, 8'h00});
        drain("readback_drain");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lut_neuron_rt.md
# lut_neuron_rt

Runtime-loadable, pipelined LUT neuron layer: NUM_NEURONS independent truth tables, each mapping an IN_BITS-wide quantised input to an OUT_BITS-wide activation. Generalises the fixed per-neuron ROM modules emitted by the LogicNets flow. Tables are written through a configuration port instead of being baked into case statements, so one bitstream serves retrained models. The block sits between layer input registers and the next layer, with valid/ready streaming on both sides.

## Interface
Parameters:
- IN_BITS, 8, input bits per neuron (table depth 2^IN_BITS)
- OUT_BITS, 2, output bits per neuron
- NUM_NEURONS, 4, parallel neurons/tables

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_start  in  1  pulse: request table load session
- cfg_we  in  1  table write strobe
- cfg_neuron  in  $clog2(NUM_NEURONS) (min 1)  target table
- cfg_addr  in  IN_BITS  table entry index
- cfg_wdata  in  OUT_BITS  entry value
- cfg_commit  in  1  pulse: end load session, enter run
- cfg_err  out  1  one-cycle pulse on rejected config action
- run  out  1  high when state is RUN
- in_valid  in  1 ; in_ready  out  1
- in_data  in  NUM_NEURONS*IN_BITS  neuron k at [k*IN_BITS +: IN_BITS]
- out_valid  out  1 ; out_ready  in  1
- out_data  out  NUM_NEURONS*OUT_BITS  neuron k at [k*OUT_BITS +: OUT_BITS]

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN. Reset → IDLE.
- IDLE: cfg_start → LOAD. cfg_we/cfg_commit → cfg_err pulse, ignored.
- LOAD: cfg_we writes table[cfg_neuron][cfg_addr] = cfg_wdata. cfg_neuron ≥ NUM_NEURONS → write dropped, cfg_err. cfg_commit → RUN. cfg_start ignored. cfg_we and cfg_commit in same cycle: write performed, then RUN.
- RUN: datapath active. cfg_start → DRAIN. cfg_we → cfg_err, dropped.
- DRAIN: in_ready=0. Pipeline keeps emitting under out_ready. When stage-1 valid and out_valid both 0 → LOAD. cfg_we → cfg_err.
- Datapath: stage 1 registered table read for every neuron (v1); stage 2 output register (out_valid). Advance enable en = !out_valid || out_ready. in_ready = (state==RUN) && en. When en: v1 <= in_valid && in_ready; out_valid <= v1; out_data <= stage-1 data.
- out_data held stable while out_valid && !out_ready.
- Table contents not reset; undefined until written. Entries not written in a session keep previous values.

## Timing
- Reset values: out_valid=0, out_data=0, cfg_err=0, run=0, in_ready=0, v1=0. Reset mid-stream discards in-flight beats; tables retained.
- Latency: input accepted at cycle t → out_valid at t+2 with no backpressure. Throughput 1 beat/cycle.
- Write in LOAD at cycle t is visible to lookups issued from cycle t+1.
- cfg_err asserted the cycle after the offending strobe, for exactly one cycle.
- run rises the cycle after the cfg_commit strobe; in_ready may be high that same cycle.
- DRAIN → LOAD at most 2 cycles after the pipeline becomes empty-capable (sooner with out_ready=1).

## Configuration
- LUT_NEURON_RT_READBACK_EN: adds ports cfg_re (in, 1) and cfg_rdata (out, OUT_BITS). In LOAD, cfg_re returns table[cfg_neuron][cfg_addr] on cfg_rdata one cycle later, held until the next read. cfg_rdata resets to 0. cfg_re outside LOAD → cfg_err.
- Without the macro: ports absent, no read mux; tables are write-only.

## Structure
- Package lut_neuron_rt_pkg: state enum (IDLE/LOAD/RUN/DRAIN), helper function for neuron-index width (min 1).
- Sub-module lut_neuron_rt_table: single IN_BITS×OUT_BITS distributed-RAM table with one write port and one registered read port, plus the optional readback port. Instantiated NUM_NEURONS times via generate.

## Test plan
- Load all tables with entry = addr[OUT_BITS-1:0] ^ neuron index, commit, stream 256 beats with in_data sweeping all entries → each out_data matches the model, latency 2, one beat/cycle.
- Hold out_ready=0 for 5 cycles mid-stream → out_data stable, in_ready=0 after pipeline fills, no beat lost or duplicated.
- cfg_we in RUN, cfg_commit in IDLE, cfg_neuron=NUM_NEURONS in LOAD → cfg_err pulse each time, tables unchanged.
- cfg_start with 2 beats in flight and out_ready=1 → both beats emitted, state reaches LOAD, rewrite entry 8'h00 of neuron 0 to 2'b11, commit, input 0 → out neuron 0 = 2'b11.
- Assert rst during streaming → next cycle out_valid=0, run=0; reload session not required: cfg_start, cfg_commit, prior table values still returned.
- (READBACK_EN) write 2'b10 to neuron 1 addr 8'h5A, cfg_re same address next cycle → cfg_rdata=2'b10 one cycle later.
